// File: rtl/nrs_pkg.sv
// Shared constants for the NRS sequence buffer: default geometry and the
// QPSK bit-pair ordering used by every read port.
package nrs_pkg;

    localparam int NRS_DEPTH_DEF = 16;
    localparam int NRS_BANKS_DEF = 2;

    // Real-part sign comes from the even index, imaginary from the odd one.
    localparam int QPSK_RE_BIT = 0;
    localparam int QPSK_IM_BIT = 1;

    function automatic int nrs_paddr_w(input int depth);
        return (depth / 2 > 1) ? $clog2(depth / 2) : 1;
    endfunction

endpackage

// File: rtl/nrs_bank.sv
// One bank of c(n) storage: a DEPTH-bit register with a single bit-write
// port and two combinational QPSK pair read ports.
module nrs_bank
    import nrs_pkg::*;
#(
    parameter int DEPTH = NRS_DEPTH_DEF,
    parameter int LINES = $clog2(DEPTH),
    parameter int PADDR = nrs_paddr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [LINES-1:0] addr,
    input  logic             d,
    input  logic [PADDR-1:0] raddr_a,
    input  logic [PADDR-1:0] raddr_b,
    output logic [1:0]       pair_a,
    output logic [1:0]       pair_b
);

    logic [DEPTH-1:0] bits_q;
    logic [DEPTH-1:0] bits_d;

    always_comb begin
        bits_d = bits_q;
        if (we) begin
            bits_d[addr] = d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bits_q <= '0;
        end else begin
            bits_q <= bits_d;
        end
    end

    always_comb begin
        pair_a = '0;
        pair_b = '0;
        pair_a[QPSK_RE_BIT] = bits_q[{raddr_a, 1'b0}];
        pair_a[QPSK_IM_BIT] = bits_q[{raddr_a, 1'b1}];
        pair_b[QPSK_RE_BIT] = bits_q[{raddr_b, 1'b0}];
        pair_b[QPSK_IM_BIT] = bits_q[{raddr_b, 1'b1}];
    end

endmodule

// File: rtl/nrs_seq_buffer.sv
// Ring of c(n) banks: the generator fills one bank while two consumers read
// QPSK bit pairs from the oldest completed bank.
module nrs_seq_buffer
    import nrs_pkg::*;
#(
    parameter int DEPTH     = NRS_DEPTH_DEF,
    parameter int NUM_BANKS = NRS_BANKS_DEF,
    parameter int LINES     = $clog2(DEPTH),
    parameter int PADDR     = nrs_paddr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             c_n,
    input  logic             c_n_valid,
    input  logic             wr_start,
    output logic             wr_ready,
    output logic             blk_done,
    output logic             overflow,
    output logic             rd_valid,
    input  logic             rd_release,
    input  logic [PADDR-1:0] rd_addr_est,
    input  logic [PADDR-1:0] rd_addr_fine,
    output logic [1:0]       nrs_est,
    output logic [1:0]       nrs_fine
);

    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int CW = $clog2(NUM_BANKS + 1);
    localparam logic [CW-1:0]    FULL = CW'(NUM_BANKS);
    localparam logic [LINES-1:0] LAST = LINES'(DEPTH - 1);

    logic [BW-1:0]    wr_bank_q, wr_bank_d;
    logic [BW-1:0]    rd_bank_q, rd_bank_d;
    logic [LINES-1:0] wr_idx_q, wr_idx_d;
    logic [CW-1:0]    full_cnt_q, full_cnt_d;
    logic             blk_done_q, blk_done_d;
    logic             overflow_q, overflow_d;

    logic                 wr_accept;
    logic                 bank_last;
    logic                 release_ok;
    logic [LINES-1:0]     wr_addr;
    logic [NUM_BANKS-1:0] bank_we;
    logic [1:0]           pair_est  [NUM_BANKS];
    logic [1:0]           pair_fine [NUM_BANKS];

    // wr_start retargets the current write to index 0, so a restart and a
    // bit arriving together never complete a bank (DEPTH >= 4).
    always_comb begin
        wr_ready   = (full_cnt_q != FULL);
        rd_valid   = (full_cnt_q != '0);
        wr_accept  = c_n_valid & wr_ready;
        release_ok = rd_release & rd_valid;
        wr_addr    = wr_start ? '0 : wr_idx_q;
        bank_last  = wr_accept & ~wr_start & (wr_idx_q == LAST);

        wr_idx_d  = wr_start ? '0 : wr_idx_q;
        wr_bank_d = wr_bank_q;
        if (wr_accept) begin
            if (bank_last) begin
                wr_idx_d  = '0;
                wr_bank_d = wr_bank_q + BW'(1);
            end else begin
                wr_idx_d = wr_addr + LINES'(1);
            end
        end

        rd_bank_d  = release_ok ? rd_bank_q + BW'(1) : rd_bank_q;
        full_cnt_d = full_cnt_q;
        case ({bank_last, release_ok})
            2'b10:   full_cnt_d = full_cnt_q + CW'(1);
            2'b01:   full_cnt_d = full_cnt_q - CW'(1);
            default: full_cnt_d = full_cnt_q;
        endcase

        blk_done_d = bank_last;
        overflow_d = c_n_valid & ~wr_ready;

        bank_we = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_we[b] = wr_accept && (wr_bank_q == BW'(b));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bank_q  <= '0;
            rd_bank_q  <= '0;
            wr_idx_q   <= '0;
            full_cnt_q <= '0;
            blk_done_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_idx_q   <= wr_idx_d;
            full_cnt_q <= full_cnt_d;
            blk_done_q <= blk_done_d;
            overflow_q <= overflow_d;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        nrs_bank #(
            .DEPTH(DEPTH),
            .LINES(LINES),
            .PADDR(PADDR)
        ) u_bank (
            .clk    (clk),
            .rst    (rst),
            .we     (bank_we[b]),
            .addr   (wr_addr),
            .d      (c_n),
            .raddr_a(rd_addr_est),
            .raddr_b(rd_addr_fine),
            .pair_a (pair_est[b]),
            .pair_b (pair_fine[b])
        );
    end

    // Reads are masked until a bank completes so stale bits never leak out.
    always_comb begin
        blk_done = blk_done_q;
        overflow = overflow_q;
        nrs_est  = rd_valid ? pair_est[rd_bank_q]  : 2'b00;
        nrs_fine = rd_valid ? pair_fine[rd_bank_q] : 2'b00;
    end

endmodule
